// File: rtl/event_latch_pkg.sv
// Shared types, limits and the saturating-increment helper for the event latch.
package event_latch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SET  = 1'b1
  } ev_state_t;

  localparam int N_MAX  = 16;
  localparam int CW_MAX = 16;

  // Increment cnt, stopping at 2**cw-1 instead of wrapping.
  function automatic logic [CW_MAX-1:0] sat_inc(input logic [CW_MAX-1:0] cnt, input int cw);
    logic [CW_MAX-1:0] lim;
    lim = CW_MAX'((32'd1 << cw) - 32'd1);
    if (cnt >= lim) return lim;
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/event_latch_slice.sv
// One event channel: sticky flag FSM, lost flag, new-event pulse and optional hit counter.
// Hit counter is present only when EVENT_LATCH_COUNT_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no unacknowledged event; ack strobes have no effect
// SET   | event latched; further events mark lost and bump the counter
module event_latch_slice
  import event_latch_pkg::*;
`ifdef EVENT_LATCH_COUNT_EN
#(
  parameter int CW = 8
)
`endif
(
  input  logic          clk1,
  input  logic          reset_n,
  input  logic          ev,
  input  logic          ack,
  output logic          flag,
  output logic          flag_d,
  output logic          new_trig,
  output logic          lost
`ifdef EVENT_LATCH_COUNT_EN
  ,
  output logic [CW-1:0] cnt_d
`endif
);

  ev_state_t state_q, state_d;
  logic      new_trig_d;
  logic      lost_d;
`ifdef EVENT_LATCH_COUNT_EN
  logic [CW-1:0] cnt_q;
`endif

  // State register plus the registered channel outputs.
  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      new_trig <= 1'b0;
      lost     <= 1'b0;
`ifdef EVENT_LATCH_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      new_trig <= new_trig_d;
      lost     <= lost_d;
`ifdef EVENT_LATCH_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next state: an event in the ack cycle keeps the channel set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ev) state_d = SET;
      SET:     if (ack && !ev) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next outputs: pulse on arm/re-arm, lost and counter updates.
  always_comb begin
    new_trig_d = 1'b0;
    lost_d     = lost;
`ifdef EVENT_LATCH_COUNT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ev) begin
          new_trig_d = 1'b1;
`ifdef EVENT_LATCH_COUNT_EN
          cnt_d      = CW'(1);
`endif
        end
      end
      SET: begin
        if (ack) begin
          lost_d     = 1'b0;
          new_trig_d = ev;
`ifdef EVENT_LATCH_COUNT_EN
          cnt_d      = ev ? CW'(1) : '0;
`endif
        end else if (ev) begin
          lost_d = 1'b1;
`ifdef EVENT_LATCH_COUNT_EN
          cnt_d  = CW'(sat_inc(CW_MAX'(cnt_q), CW));
`endif
        end
      end
      default: ;
    endcase
  end

  assign flag   = (state_q == SET);
  assign flag_d = (state_d == SET);

endmodule

// File: rtl/event_latch.sv
// Sticky event latch for host polling: N channels, pending summary and freezable snapshot.
// Define EVENT_LATCH_COUNT_EN to build per-channel saturating hit counters into snap_cnt;
// otherwise snap_cnt is constant zero.
module event_latch
  import event_latch_pkg::*;
#(
  parameter int N    = 8,
  parameter int CW   = 8,
  parameter int EDGE = 0
) (
  input  logic          clk1,
  input  logic          reset_n,
  input  logic [N-1:0]  ev_in,
  input  logic [N-1:0]  ack_trig,
  input  logic          freeze,
  output logic [N-1:0]  flags,
  output logic          pending,
  output logic [N-1:0]  new_trig,
  output logic [N-1:0]  lost,
  output logic [N-1:0]  snap_flags,
  output logic [N*CW-1:0] snap_cnt
);

  logic [N-1:0] ev;
  logic [N-1:0] flag_d;
`ifdef EVENT_LATCH_COUNT_EN
  logic [N*CW-1:0] cnt_d;
`endif

  generate
    if (EDGE != 0) begin : g_edge
      logic [N-1:0] prev;
      // Level history; cleared in reset so a level held through release counts once.
      always_ff @(posedge clk1) begin
        if (!reset_n) prev <= '0;
        else          prev <= ev_in;
      end
      assign ev = ev_in & ~prev;
    end else begin : g_pulse
      assign ev = ev_in;
    end
  endgenerate

  for (genvar i = 0; i < N; i++) begin : g_ch
    event_latch_slice
`ifdef EVENT_LATCH_COUNT_EN
      #(.CW(CW))
`endif
    u_slice (
      .clk1     (clk1),
      .reset_n  (reset_n),
      .ev       (ev[i]),
      .ack      (ack_trig[i]),
      .flag     (flags[i]),
      .flag_d   (flag_d[i]),
      .new_trig (new_trig[i]),
      .lost     (lost[i])
`ifdef EVENT_LATCH_COUNT_EN
      ,
      .cnt_d    (cnt_d[i*CW +: CW])
`endif
    );
  end

  // Pending summary and flag snapshot, both built from next-state so they align with flags.
  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      snap_flags <= '0;
    end else begin
      pending <= |flag_d;
      if (!freeze) snap_flags <= flag_d;
    end
  end

`ifdef EVENT_LATCH_COUNT_EN
  // Counter snapshot follows the same freeze rule as the flag snapshot.
  always_ff @(posedge clk1) begin
    if (!reset_n)    snap_cnt <= '0;
    else if (!freeze) snap_cnt <= cnt_d;
  end
`else
  assign snap_cnt = '0;
`endif

endmodule

// File: tb/tb_event_latch.sv
// Directed bench for event_latch: a pulse-mode instance driven from a vector table plus
// hand sequences, and a level/edge-mode instance for the edge-detect corner cases.
module tb_event_latch;

`ifdef EVENT_LATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        reset_n;
  logic [7:0]  ev0, ack0, ev1, ack1;
  logic        frz0, frz1;
  logic [7:0]  flags0, nt0, lost0, snap0;
  logic [7:0]  flags1, nt1, lost1, snap1;
  logic        pend0, pend1;
  logic [63:0] scnt0, scnt1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk1 = ~clk1;

  event_latch #(.N(8), .CW(8), .EDGE(0)) u_dut0 (
    .clk1(clk1), .reset_n(reset_n), .ev_in(ev0), .ack_trig(ack0), .freeze(frz0),
    .flags(flags0), .pending(pend0), .new_trig(nt0), .lost(lost0),
    .snap_flags(snap0), .snap_cnt(scnt0)
  );

  event_latch #(.N(8), .CW(8), .EDGE(1)) u_dut1 (
    .clk1(clk1), .reset_n(reset_n), .ev_in(ev1), .ack_trig(ack1), .freeze(frz1),
    .flags(flags1), .pending(pend1), .new_trig(nt1), .lost(lost1),
    .snap_flags(snap1), .snap_cnt(scnt1)
  );

  typedef struct {
    logic [7:0] ev;
    logic [7:0] ack;
    logic       frz;
    logic [7:0] flags;
    logic [7:0] nt;
    logic [7:0] lost;
    logic       pend;
    logic [7:0] snap;
    logic [7:0] cnt0;
  } vec_t;

  vec_t vt [15];

  function automatic logic [7:0] ecnt(input logic [7:0] v);
    return CNT_ON ? v : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    int pulses;
    logic [7:0] nt_seen;

    //          ev     ack    frz   flags  nt     lost   pend  snap   cnt0
    vt[0]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1, 8'h01, 8'h01};
    vt[1]  = '{8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01};
    vt[2]  = '{8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 8'h01, 8'h02};
    vt[3]  = '{8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[4]  = '{8'h00, 8'h02, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[5]  = '{8'h06, 8'h00, 1'b0, 8'h06, 8'h06, 8'h00, 1'b1, 8'h06, 8'h00};
    vt[6]  = '{8'h02, 8'h02, 1'b0, 8'h06, 8'h02, 8'h00, 1'b1, 8'h06, 8'h00};
    vt[7]  = '{8'h04, 8'h00, 1'b0, 8'h06, 8'h00, 8'h04, 1'b1, 8'h06, 8'h00};
    vt[8]  = '{8'h80, 8'h06, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 8'h80, 8'h00};
    vt[9]  = '{8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[10] = '{8'h03, 8'h00, 1'b0, 8'h03, 8'h03, 8'h00, 1'b1, 8'h03, 8'h01};
    vt[11] = '{8'h04, 8'h03, 1'b1, 8'h04, 8'h04, 8'h00, 1'b1, 8'h03, 8'h01};
    vt[12] = '{8'h00, 8'h00, 1'b1, 8'h04, 8'h00, 8'h00, 1'b1, 8'h03, 8'h01};
    vt[13] = '{8'h00, 8'h00, 1'b0, 8'h04, 8'h00, 8'h00, 1'b1, 8'h04, 8'h00};
    vt[14] = '{8'h00, 8'h04, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};

    // Reset with every input asserted; ch3 level on the edge instance held across release.
    reset_n = 1'b0;
    ev0 = 8'hFF; ack0 = 8'hFF; frz0 = 1'b0;
    ev1 = 8'h08; ack1 = 8'h00; frz1 = 1'b0;
    step();
    step();
    chk("rst_flags", flags0, 8'h00);
    chk("rst_new", nt0, 8'h00);
    chk("rst_pend", pend0, 1'b0);

    reset_n = 1'b1;
    ev0 = 8'h00; ack0 = 8'h00;
    step();
    chk("post_rst_flags", flags0, 8'h00);
    chk("post_rst_new", nt0, 8'h00);
    chk("post_rst_lost", lost0, 8'h00);
    chk("post_rst_pend", pend0, 1'b0);
    chk("post_rst_snap", snap0, 8'h00);
    chk("post_rst_cnt", scnt0, 64'h0);
    chk("edge_rel_flags", flags1, 8'h08);
    chk("edge_rel_new", nt1, 8'h08);
    step();
    chk("edge_hold_new", nt1, 8'h00);
    ev1 = 8'h00; ack1 = 8'h08;
    step();
    chk("edge_ack_flags", flags1, 8'h00);
    ack1 = 8'h00;

    // Vector table on the pulse-mode instance.
    for (int i = 0; i < 15; i++) begin
      ev0 = vt[i].ev; ack0 = vt[i].ack; frz0 = vt[i].frz;
      step();
      chk($sformatf("v%0d_flags", i), flags0, vt[i].flags);
      chk($sformatf("v%0d_new", i), nt0, vt[i].nt);
      chk($sformatf("v%0d_lost", i), lost0, vt[i].lost);
      chk($sformatf("v%0d_pend", i), pend0, vt[i].pend);
      chk($sformatf("v%0d_snap", i), snap0, vt[i].snap);
      chk($sformatf("v%0d_cnt0", i), scnt0[7:0], ecnt(vt[i].cnt0));
    end
    ev0 = 8'h00; ack0 = 8'h00; frz0 = 1'b0;

    // Saturation: set ch0 then 300 back-to-back events.
    ev0 = 8'h01;
    step();
    chk("sat_first_new", nt0, 8'h01);
    nt_seen = 8'h00;
    for (int k = 0; k < 300; k++) begin
      step();
      nt_seen = nt_seen | nt0;
    end
    chk("sat_no_new", nt_seen, 8'h00);
    chk("sat_lost", lost0, 8'h01);
    chk("sat_cnt0", scnt0[7:0], ecnt(8'hFF));
    ev0 = 8'h00; ack0 = 8'h01;
    step();
    chk("sat_clr_flags", flags0, 8'h00);
    chk("sat_clr_lost", lost0, 8'h00);
    ack0 = 8'h00;

    // Ack and event in the same cycle: event wins, lost cleared, counter restarts.
    ev0 = 8'h01;
    step();
    step();
    chk("ackev_pre_lost", lost0, 8'h01);
    chk("ackev_pre_cnt", scnt0[7:0], ecnt(8'h02));
    ack0 = 8'h01;
    step();
    chk("ackev_flags", flags0, 8'h01);
    chk("ackev_new", nt0, 8'h01);
    chk("ackev_lost", lost0, 8'h00);
    chk("ackev_cnt", scnt0[7:0], ecnt(8'h01));
    ev0 = 8'h00;
    step();
    chk("ack_only_flags", flags0, 8'h00);
    chk("ack_only_pend", pend0, 1'b0);
    ack0 = 8'h00;

    // Edge mode: ch2 level held 10 cycles gives exactly one event.
    ev1 = 8'h04;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (nt1[2]) pulses++;
    end
    chk("edge_pulses", pulses, 1);
    chk("edge_flags", flags1, 8'h04);
    chk("edge_lost", lost1, 8'h00);
    chk("edge_cnt2", scnt1[23:16], ecnt(8'h01));
    ev1 = 8'h00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
